// File: rtl/icache_sa_if.sv
// Fetch-side lookup and memory-side word request/valid signals of icache_sa, grouped for port passing.
// The cache takes the slave view; the instruction unit and memory controller together take the master view.
interface icache_sa_if;
   logic [31:0] addrIn;
   logic        hit;
   logic [31:0] dataOut;
   logic        validIn;
   logic [31:0] dataIn;
   logic        memFlag;
   logic [31:0] addrOut;

   modport slave  (input  addrIn, validIn, dataIn, output hit, dataOut, memFlag, addrOut);
   modport master (output addrIn, validIn, dataIn, input  hit, dataOut, memFlag, addrOut);
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, line refill as 2^LINE_WORD_WIDTH sequential word requests.
// Hits under a refill; readyIn=0 freezes all state. ICACHE_FLUSH_EN adds flushIn (clear all lines, abort refill).
module icache_sa #(
   parameter int WAYS            = 2,
   parameter int SET_WIDTH       = 6,
   parameter int LINE_WORD_WIDTH = 2,
   parameter int TAG_WIDTH       = 7
) (
   input  logic        clockIn,
   input  logic        resetNIn,
   input  logic        readyIn,
`ifdef ICACHE_FLUSH_EN
   input  logic        flushIn,
`endif
   icache_sa_if.slave  bus
);
   localparam int WORDS   = 1 << LINE_WORD_WIDTH;
   localparam int SETS    = 1 << SET_WIDTH;
   localparam int PW      = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LSB_SET = LINE_WORD_WIDTH + 2;
   localparam int LSB_TAG = LSB_SET + SET_WIDTH;

   typedef logic [PW-1:0] way_t;
   typedef enum logic {IDLE, REFILL} state_t;

   state_t state_q, state_d;

   logic [WAYS-1:0]      valid_q [SETS];
   way_t                 ptr_q   [SETS];
   logic [TAG_WIDTH-1:0] tags_q  [WAYS][SETS];
   logic [31:0]          data_q  [WAYS][SETS][WORDS];

   logic [31-LSB_SET:0]        line_q;
   logic [LINE_WORD_WIDTH-1:0] cnt_q;
   way_t                       victim_q;
   logic                       memreq_q;

   logic [SET_WIDTH-1:0]       a_set, r_set;
   logic [TAG_WIDTH-1:0]       a_tag, r_tag;
   logic [LINE_WORD_WIDTH-1:0] a_off;
   logic                       hit_w;
   logic [31:0]                rdata_w;
   logic                       flush_w;
   logic                       do_flush, do_miss, do_write, do_last;
   way_t                       ptr_nxt;
   logic                       unused_addr_bits;

   assign a_set = bus.addrIn[LSB_TAG-1:LSB_SET];
   assign a_tag = bus.addrIn[LSB_TAG+TAG_WIDTH-1:LSB_TAG];
   assign a_off = bus.addrIn[LSB_SET-1:2];
   // The refill target is recovered from the latched line number.
   assign r_set = line_q[SET_WIDTH-1:0];
   assign r_tag = line_q[SET_WIDTH+TAG_WIDTH-1:SET_WIDTH];
   assign unused_addr_bits = ^bus.addrIn[1:0];

`ifdef ICACHE_FLUSH_EN
   assign flush_w = flushIn;
`else
   assign flush_w = 1'b0;
`endif

   always_comb begin
      hit_w   = 1'b0;
      rdata_w = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[a_set][w] && (tags_q[w][a_set] == a_tag)) begin
            hit_w   = 1'b1;
            rdata_w = rdata_w | data_q[w][a_set][a_off];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      do_flush = 1'b0;
      do_miss  = 1'b0;
      do_write = 1'b0;
      do_last  = 1'b0;
      if (readyIn) begin
         if (flush_w) begin
            do_flush = 1'b1;
            state_d  = IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (!hit_w) begin
                     do_miss = 1'b1;
                     state_d = REFILL;
                  end
               end
               REFILL: begin
                  if (bus.validIn) begin
                     do_write = 1'b1;
                     if (&cnt_q) begin
                        do_last = 1'b1;
                        state_d = IDLE;
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clockIn or negedge resetNIn) begin
      if (!resetNIn) state_q <= IDLE;
      else           state_q <= state_d;
   end

   assign ptr_nxt = (WAYS == 1) ? '0 : way_t'(ptr_q[r_set] + 1'b1);

   always_ff @(posedge clockIn or negedge resetNIn) begin
      if (!resetNIn) begin
         memreq_q <= 1'b0;
         line_q   <= '0;
         cnt_q    <= '0;
         victim_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         if (do_flush) begin
            memreq_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
               valid_q[s] <= '0;
               ptr_q[s]   <= '0;
            end
         end
         // Invalidate the victim up front so no lookup can hit a half-written line.
         if (do_miss) begin
            valid_q[a_set][ptr_q[a_set]] <= 1'b0;
            victim_q <= ptr_q[a_set];
            line_q   <= bus.addrIn[31:LSB_SET];
            cnt_q    <= '0;
            memreq_q <= 1'b1;
         end
         if (do_write) begin
            cnt_q <= cnt_q + 1'b1;
            if (do_last) begin
               valid_q[r_set][victim_q] <= 1'b1;
               ptr_q[r_set]             <= ptr_nxt;
               memreq_q                 <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clockIn) begin
      if (do_write) data_q[victim_q][r_set][cnt_q] <= bus.dataIn;
      if (do_last)  tags_q[victim_q][r_set]        <= r_tag;
   end

   assign bus.hit     = hit_w;
   assign bus.dataOut = rdata_w;
   assign bus.memFlag = memreq_q & ~(bus.validIn & readyIn);
   assign bus.addrOut = {line_q, cnt_q, 2'b00};
endmodule
